// File: rtl/pc_gen_unit_pkg.sv
// Shared constants and types for the fetch-PC generator: default vectors,
// cause codes and the RUN/HANDLER state encoding.
package pc_pkg;

    localparam logic [31:0] RESET_VEC_DFLT = 32'h0000_0000;
    localparam logic [31:0] EXC_VEC_DFLT   = 32'h0000_4180;

    localparam logic [4:0] CAUSE_NONE = 5'd0;
    localparam logic [4:0] CAUSE_ADEL = 5'd4;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_HANDLER = 1'b1
    } pc_state_t;

endpackage

// File: rtl/pc_gen_unit_if.sv
// ID-redirect / exception bus between the pipeline control and the fetch-PC generator.
interface pc_gen_unit_if #(
    parameter int XLEN    = 32,
    parameter int CAUSE_W = 5
);
    logic               stall;
    logic [XLEN-1:0]    id_pc;
    logic               br_taken;
    logic [15:0]        br_imm;
    logic               jump;
    logic [25:0]        j_index;
    logic               jr;
    logic [XLEN-1:0]    jr_target;
    logic               exc_req;
    logic [XLEN-1:0]    exc_pc;
    logic [CAUSE_W-1:0] exc_code;
    logic               eret;

    logic [XLEN-1:0]    pc;
    logic               flush_if;
    logic [XLEN-1:0]    epc;
    logic [CAUSE_W-1:0] cause;
    logic               in_handler;
    logic               dbl_fault;

    modport master (
        output stall, id_pc, br_taken, br_imm, jump, j_index, jr, jr_target,
               exc_req, exc_pc, exc_code, eret,
        input  pc, flush_if, epc, cause, in_handler, dbl_fault
    );

    modport slave (
        input  stall, id_pc, br_taken, br_imm, jump, j_index, jr, jr_target,
               exc_req, exc_pc, exc_code, eret,
        output pc, flush_if, epc, cause, in_handler, dbl_fault
    );
endinterface

// File: rtl/pc_gen_unit_target_calc.sv
// Combinational branch and jump target computation for the instruction in ID.
module pc_target_calc
    import pc_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] id_pc,
    input  logic [15:0]     br_imm,
    input  logic [25:0]     j_index,
    output logic [XLEN-1:0] br_tgt,
    output logic [XLEN-1:0] j_tgt
);

    // Word offset sign-extended and scaled to bytes; the add wraps mod 2^XLEN.
    logic signed [XLEN-1:0] br_off;

    assign br_off = {{(XLEN-18){br_imm[15]}}, br_imm, 2'b00};
    assign br_tgt = id_pc + XLEN'(4) + $unsigned(br_off);
    assign j_tgt  = {id_pc[XLEN-1:28], j_index, 2'b00};

endmodule

// File: rtl/pc_gen_unit.sv
// Registered fetch-PC generator with ID redirects, precise exception entry,
// EPC/CAUSE capture and a RUN/HANDLER state machine for ERET.
module pc_gen_unit
    import pc_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = XLEN'(RESET_VEC_DFLT),
    parameter logic [XLEN-1:0] EXC_VEC   = XLEN'(EXC_VEC_DFLT),
    parameter int              CAUSE_W   = 5
) (
    input logic          clk,
    input logic          rst,
    pc_gen_unit_if.slave bus
);

    pc_state_t          state_q, state_nxt;
    logic [XLEN-1:0]    pc_q, pc_nxt;
    logic [XLEN-1:0]    epc_q, epc_nxt;
    logic [CAUSE_W-1:0] cause_q, cause_nxt;
    logic               flush_q, flush_nxt;
    logic               dbl_q, dbl_nxt;
    logic [XLEN-1:0]    br_tgt, j_tgt;
    logic               jr_adel, take_exc;

    pc_target_calc #(.XLEN(XLEN)) u_target (
        .id_pc   (bus.id_pc),
        .br_imm  (bus.br_imm),
        .j_index (bus.j_index),
        .br_tgt  (br_tgt),
        .j_tgt   (j_tgt)
    );

    // A misaligned JR is only an error if it would actually redirect.
    assign jr_adel  = bus.jr && !bus.stall && (bus.jr_target[1:0] != 2'b00);
    assign take_exc = bus.exc_req || jr_adel;

    always_comb begin
        pc_nxt    = pc_q + XLEN'(4);
        epc_nxt   = epc_q;
        cause_nxt = cause_q;
        state_nxt = state_q;
        flush_nxt = 1'b0;
        dbl_nxt   = dbl_q;
        if (take_exc) begin
            pc_nxt    = EXC_VEC;
            flush_nxt = 1'b1;
            if (state_q == ST_RUN) begin
                epc_nxt   = bus.exc_req ? bus.exc_pc   : bus.id_pc;
                cause_nxt = bus.exc_req ? bus.exc_code : CAUSE_W'(CAUSE_ADEL);
                state_nxt = ST_HANDLER;
            end else begin
                dbl_nxt = 1'b1;
            end
        end else if (bus.stall) begin
            pc_nxt = pc_q;
        end else if (bus.eret) begin
            // ERET outside a handler falls through to sequential fetch.
            if (state_q == ST_HANDLER) begin
                pc_nxt    = epc_q;
                state_nxt = ST_RUN;
                flush_nxt = 1'b1;
            end
        end else if (bus.jr) begin
            pc_nxt    = bus.jr_target;
            flush_nxt = 1'b1;
        end else if (bus.jump) begin
            pc_nxt    = j_tgt;
            flush_nxt = 1'b1;
        end else if (bus.br_taken) begin
            pc_nxt    = br_tgt;
            flush_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_VEC;
            epc_q   <= '0;
            cause_q <= CAUSE_W'(CAUSE_NONE);
            flush_q <= 1'b0;
            dbl_q   <= 1'b0;
        end else begin
            state_q <= state_nxt;
            pc_q    <= pc_nxt;
            epc_q   <= epc_nxt;
            cause_q <= cause_nxt;
            flush_q <= flush_nxt;
            dbl_q   <= dbl_nxt;
        end
    end

    assign bus.pc         = pc_q;
    assign bus.flush_if   = flush_q;
    assign bus.epc        = epc_q;
    assign bus.cause      = cause_q;
    assign bus.in_handler = (state_q == ST_HANDLER);
    assign bus.dbl_fault  = dbl_q;

endmodule
